// File: rtl/usb_class_pkg.sv
// usb_class_pkg: USB device-class codes and the class sequencer state encoding.
// Shared by the class sequencer, the USB top and the register block.
package usb_class_pkg;

  localparam logic [2:0] CLS_NONE     = 3'd0;
  localparam logic [2:0] CLS_AUDIO    = 3'd1;
  localparam logic [2:0] CLS_CAMERA   = 3'd2;
  localparam logic [2:0] CLS_DISK     = 3'd3;
  localparam logic [2:0] CLS_KEYBOARD = 3'd4;
  localparam logic [2:0] CLS_SERIAL   = 3'd5;
  localparam logic [2:0] CLS_MAX      = 3'd5;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DETACH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ON     = 2'd3
  } seq_state_e;

  // Core release mask for a class: bit k-1 for class k, nothing for none/illegal.
  function automatic logic [4:0] cls_onehot(input logic [2:0] cls);
    logic [4:0] mask;
    mask = 5'b0;
    if (cls != CLS_NONE && cls <= CLS_MAX) mask = 5'b00001 << (cls - 3'd1);
    return mask;
  endfunction

endpackage

// File: rtl/usb_class_seq_timer.sv
// usb_seq_timer: loadable down-counter for the detach/settle intervals.
// Holds at zero once it gets there; zero flags the last cycle of an interval.
module usb_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/usb_class_seq.sv
// usb_class_seq: device-class switch sequencer (detach, settle, attach).
// Build option: USB_CLASS_SEQ_PREEMPT_EN lets a request be taken during SETTLE,
// replacing the target and restarting the settle interval.
//
// state  | meaning
// OFF    | no class selected, pads idle, pull-up off
// DETACH | pull-up forced off, old class still muxed, all cores in reset
// SETTLE | new class muxed in, its core still in reset
// ON     | target core released, pull-up enabled
module usb_class_seq
  import usb_class_pkg::*;
#(
  parameter int DETACH_CYCLES = 60000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic [2:0] req_class_i,
  output logic       req_ready_o,
  output logic [2:0] class_o,
  output logic [4:0] core_rstn_o,
  output logic       pull_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       illegal_o
);

`ifdef USB_CLASS_SEQ_PREEMPT_EN
  localparam bit PREEMPT_EN = 1'b1;
`else
  localparam bit PREEMPT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DETACH_LOAD = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state;
  logic [2:0]       tgt;
  logic             accept;
  logic             req_bad;
  logic [2:0]       req_cls;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  usb_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Request decode and timer load on every entry into DETACH or SETTLE.
  always_comb begin
    req_bad   = (req_class_i > CLS_MAX);
    req_cls   = req_bad ? CLS_SERIAL : req_class_i;
    accept    = req_valid_i & req_ready_o;
    tmr_load  = 1'b0;
    tmr_value = SETTLE_LOAD;
    case (state)
      ST_OFF:    tmr_load = accept && (req_cls != CLS_NONE);
      ST_ON: begin
        tmr_load  = accept && (req_cls != tgt);
        tmr_value = DETACH_LOAD;
      end
      ST_DETACH: tmr_load = tmr_zero && (tgt != CLS_NONE);
      ST_SETTLE: tmr_load = PREEMPT_EN && accept && (req_cls != CLS_NONE);
      default:   tmr_load = 1'b0;
    endcase
  end

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_OFF;
      tgt         <= CLS_NONE;
      class_o     <= CLS_NONE;
      core_rstn_o <= 5'b0;
      pull_en_o   <= 1'b0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) illegal_o <= req_bad;
      case (state)
        ST_OFF: begin
          if (accept) begin
            if (req_cls == CLS_NONE) begin
              done_o <= 1'b1;
            end else begin
              state       <= ST_SETTLE;
              tgt         <= req_cls;
              class_o     <= req_cls;
              req_ready_o <= PREEMPT_EN;
              busy_o      <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (accept) begin
            if (req_cls == tgt) begin
              done_o <= 1'b1;
            end else begin
              // class_o keeps the old class while the host sees the detach
              state       <= ST_DETACH;
              tgt         <= req_cls;
              core_rstn_o <= 5'b0;
              pull_en_o   <= 1'b0;
              req_ready_o <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
        end
        ST_DETACH: begin
          if (tmr_zero) begin
            if (tgt == CLS_NONE) begin
              state       <= ST_OFF;
              class_o     <= CLS_NONE;
              req_ready_o <= 1'b1;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              state       <= ST_SETTLE;
              class_o     <= tgt;
              req_ready_o <= PREEMPT_EN;
            end
          end
        end
        ST_SETTLE: begin
          if (PREEMPT_EN && accept) begin
            if (req_cls == CLS_NONE) begin
              state       <= ST_OFF;
              tgt         <= CLS_NONE;
              class_o     <= CLS_NONE;
              req_ready_o <= 1'b1;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              tgt     <= req_cls;
              class_o <= req_cls;
            end
          end else if (tmr_zero) begin
            state       <= ST_ON;
            core_rstn_o <= cls_onehot(tgt);
            pull_en_o   <= 1'b1;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_class_seq.sv
// Directed bench for usb_class_seq with DETACH_CYCLES=8, SETTLE_CYCLES=4.
module tb_usb_class_seq;

`ifdef USB_CLASS_SEQ_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] cls;
    logic [4:0] rstn;
    logic       pull;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       ill;
  } outs_t;

  typedef struct {
    logic       valid;
    logic [2:0] cls;
    outs_t      exp;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic [2:0] req_class_i = 3'd0;
  logic       req_ready_o;
  logic [2:0] class_o;
  logic [4:0] core_rstn_o;
  logic       pull_en_o;
  logic       busy_o;
  logic       done_o;
  logic       illegal_o;

  int n_vec = 0;
  int n_fail = 0;
  vec_t vecs[$];

  usb_class_seq #(.DETACH_CYCLES(8), .SETTLE_CYCLES(4), .CNT_W(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_class_i(req_class_i),
    .req_ready_o(req_ready_o),
    .class_o    (class_o),
    .core_rstn_o(core_rstn_o),
    .pull_en_o  (pull_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic outs_t o_off(input logic done, input logic ill);
    return '{cls: 3'd0, rstn: 5'b0, pull: 1'b0, rdy: 1'b1, busy: 1'b0, done: done, ill: ill};
  endfunction
  function automatic outs_t o_settle(input logic [2:0] c, input logic ill);
    return '{cls: c, rstn: 5'b0, pull: 1'b0, rdy: PRE, busy: 1'b1, done: 1'b0, ill: ill};
  endfunction
  function automatic outs_t o_detach(input logic [2:0] c, input logic ill);
    return '{cls: c, rstn: 5'b0, pull: 1'b0, rdy: 1'b0, busy: 1'b1, done: 1'b0, ill: ill};
  endfunction
  function automatic outs_t o_on(input logic [2:0] c, input logic [4:0] r, input logic done,
                                 input logic ill);
    return '{cls: c, rstn: r, pull: 1'b1, rdy: 1'b1, busy: 1'b0, done: done, ill: ill};
  endfunction

  function automatic outs_t cur();
    return '{cls: class_o, rstn: core_rstn_o, pull: pull_en_o, rdy: req_ready_o,
             busy: busy_o, done: done_o, ill: illegal_o};
  endfunction

  task automatic add(input logic v, input logic [2:0] c, input outs_t e);
    vec_t t;
    t.valid = v;
    t.cls   = c;
    t.exp   = e;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = cur();
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cls=%0d rstn=%b pull=%b rdy=%b busy=%b done=%b ill=%b, want cls=%0d rstn=%b pull=%b rdy=%b busy=%b done=%b ill=%b",
               name, act.cls, act.rstn, act.pull, act.rdy, act.busy, act.done, act.ill,
               exp.cls, exp.rstn, exp.pull, exp.rdy, exp.busy, exp.done, exp.ill);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c);
    req_valid_i = v;
    req_class_i = c;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int edges;
    int accepts;
    bit saw_on4;
    bit found;
    bit rdy_before;

    // A: OFF -> class 3, settle only
    add(1, 3, o_settle(3, 0));
    for (int i = 0; i < 3; i++) add(0, 0, o_settle(3, 0));
    add(0, 0, o_on(3, 5'b00100, 1, 0));
    add(0, 0, o_on(3, 5'b00100, 0, 0));
    // B: ON(3) -> 5, 8 detach + 4 settle
    add(1, 5, o_detach(3, 0));
    for (int i = 0; i < 7; i++) add(0, 0, o_detach(3, 0));
    for (int i = 0; i < 4; i++) add(0, 0, o_settle(5, 0));
    add(0, 0, o_on(5, 5'b10000, 1, 0));
    add(0, 0, o_on(5, 5'b10000, 0, 0));
    // C: same-class no-op
    add(1, 5, o_on(5, 5'b10000, 1, 0));
    add(0, 0, o_on(5, 5'b10000, 0, 0));
    // D: go OFF, no-op 0 in OFF, illegal 7 from OFF, then 0 clears illegal
    add(1, 0, o_detach(5, 0));
    for (int i = 0; i < 7; i++) add(0, 0, o_detach(5, 0));
    add(0, 0, o_off(1, 0));
    add(0, 0, o_off(0, 0));
    add(1, 0, o_off(1, 0));
    add(0, 0, o_off(0, 0));
    add(1, 7, o_settle(5, 1));
    for (int i = 0; i < 3; i++) add(0, 0, o_settle(5, 1));
    add(0, 0, o_on(5, 5'b10000, 1, 1));
    add(0, 0, o_on(5, 5'b10000, 0, 1));
    add(1, 0, o_detach(5, 0));
    for (int i = 0; i < 7; i++) add(0, 0, o_detach(5, 0));
    add(0, 0, o_off(1, 0));
    add(0, 0, o_off(0, 0));

    // Reset
    repeat (3) @(posedge clk_i);
    #1;
    check_outs("reset_values", o_off(0, 0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_outs("after_release", o_off(0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].cls);
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
    end
    step(0, 0);

    // Held request during a 1 -> 4 switch
    step(1, 1);
    check_outs("hold_settle1", o_settle(1, 0));
    req_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0);
      found = (core_rstn_o == 5'b00001) && pull_en_o;
    end
    check_int("hold_on1_reached", int'(found), 1);
    step(0, 0);
    step(1, 4);
    check_outs("hold_detach1", o_detach(1, 0));
    req_class_i = 3'd2;
    edges = 0;
    accepts = 0;
    saw_on4 = 1'b0;
    found = 1'b0;
    while (edges < 60 && !found) begin
      rdy_before = req_ready_o;
      @(posedge clk_i);
      #1;
      edges++;
      if (rdy_before && req_valid_i) begin
        accepts++;
        req_valid_i = 1'b0;
      end
      if (core_rstn_o == 5'b01000) saw_on4 = 1'b1;
      found = (core_rstn_o == 5'b00010) && pull_en_o;
    end
    check_int("hold_on2_reached", int'(found), 1);
    check_int("hold_accepts", accepts, 1);
    check_int("hold_edges", edges, PRE ? 13 : 25);
    check_int("hold_saw_on4", int'(saw_on4), PRE ? 0 : 1);
    check_outs("hold_on2", o_on(2, 5'b00010, 1, 0));

    // Async reset mid-DETACH
    step(1, 3);
    check_outs("rst_detach", o_detach(2, 0));
    step(0, 0);
    step(0, 0);
    #3;
    rst_ni = 1'b0;
    #1;
    check_outs("rst_async", o_off(0, 0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_outs("rst_released", o_off(0, 0));
    step(1, 1);
    check_outs("post_rst_settle", o_settle(1, 0));
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      check_outs("post_rst_settle_n", o_settle(1, 0));
    end
    step(0, 0);
    check_outs("post_rst_on1", o_on(1, 5'b00001, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_class_seq.md
# usb_class_seq

Sequencer for the USB peripheral's device-class selector; replaces the direct class-select path from the control register. On each class-change request it detaches from the host by dropping the D+ pull-up, holds every class core in reset for a settle interval, then attaches the new core. It sits between the USB register block (class code, status) and the per-class core resets, pull-up and pad mux select.

## Interface
- DETACH_CYCLES, 60000: cycles pull-up is forced off before a class switch (1 ms at 60 MHz); must be ≥1.
- SETTLE_CYCLES, 16: cycles the new class is muxed in with its core still in reset; must be ≥1.
- CNT_W, 16: timer width; must hold max(DETACH_CYCLES, SETTLE_CYCLES)−1.

- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  class-change request.
- req_class_i  in  3  requested class; 0 none, 1 audio, 2 camera, 3 disk, 4 keyboard, 5 serial, 6/7 illegal.
- req_ready_o  out  1  request accepted when valid&ready.
- class_o  out  3  pad/mux select; 0 = no core drives pads.
- core_rstn_o  out  5  active-low core resets, bit k−1 for class k; at most one bit high.
- pull_en_o  out  1  gate for the selected core's D+ pull-up.
- busy_o  out  1  high in DETACH or SETTLE.
- done_o  out  1  one-cycle pulse when a sequence completes.
- illegal_o  out  1  sticky; set when class 6/7 is accepted, cleared by the next legal accepted request.

## Operation
- States: OFF, DETACH, SETTLE, ON. Target register tgt holds the accepted class.
- Illegal classes 6/7 are mapped to 5 (serial) and set illegal_o.
- OFF: class_o=0, core_rstn_o=0, pull_en_o=0, req_ready_o=1.
  - Accept class 0: done_o pulse next cycle; stay OFF.
  - Accept class k≠0: tgt=k, go to SETTLE. No detach, since nothing is attached.
- ON: class_o=tgt, core_rstn_o[tgt−1]=1, pull_en_o=1, req_ready_o=1.
  - Accept class == tgt: no-op; done_o pulse next cycle.
  - Accept any other class: tgt=new, go to DETACH.
- DETACH: class_o=old class, pull_en_o=0, all core_rstn_o=0, req_ready_o=0. Runs for DETACH_CYCLES cycles.
  - Then tgt==0 goes to OFF with done_o pulse.
  - Otherwise go to SETTLE.
- SETTLE: class_o=tgt, core_rstn_o=0, pull_en_o=0, req_ready_o=0. Runs for SETTLE_CYCLES cycles, then goes to ON with done_o pulse.
- Timer: down-counter loaded with N−1 on state entry; the state exits on the cycle the count is 0.
- Reset assertion at any time forces OFF immediately (asynchronous). Any sequence in progress is discarded and illegal_o is cleared.

## Timing
- All outputs are registered; reset values: req_ready_o=1, every other output 0.
- The request is sampled on edge E. The state and all outputs for the new state are valid after E.
- DETACH lasts exactly DETACH_CYCLES cycles; SETTLE lasts exactly SETTLE_CYCLES cycles.
- done_o is high during the first cycle of ON or OFF. For a no-op, done_o is high in the cycle after acceptance.
- Switch latency from ON is DETACH+SETTLE cycles. From OFF it is SETTLE cycles.
- req_valid_i held while req_ready_o=0 is not lost. It is accepted on the first ready cycle.

## Configuration
- USB_CLASS_SEQ_PREEMPT_EN defined:
  - req_ready_o is also 1 in SETTLE.
  - A request accepted in SETTLE replaces tgt and reloads the SETTLE timer.
  - Class 0 accepted in SETTLE goes to OFF with done_o.
  - Same-class requests in SETTLE are also reloads.
- Undefined: req_ready_o=0 throughout DETACH and SETTLE.

## Structure
- Package usb_class_pkg holds:
  - class code constants CLS_NONE..CLS_SERIAL (3 bits) and CLS_MAX=5;
  - state enum OFF/DETACH/SETTLE/ON.
- The package is shared with the USB top and the register block.
- Sub-module usb_seq_timer: loadable CNT_W down-counter with load, value and zero flag.

## Test plan
- Bench uses DETACH_CYCLES=8, SETTLE_CYCLES=4.
- Reset, then request class 3 from OFF → class_o=3 with core_rstn_o=0 for 4 cycles; then core_rstn_o=5'b00100, pull_en_o=1, done_o one pulse.
- In ON(3), request 5 → pull_en_o=0 and class_o=3 for 8 cycles; class_o=5 for 4 cycles; then core_rstn_o=5'b10000, done_o pulse. Total 12 cycles.
- In ON(5), request 5 → no output change; req_ready_o stays 1; done_o pulse next cycle.
- Request 7 from OFF → illegal_o=1, ends ON(5). Request 0 next → 8-cycle detach, then OFF, illegal_o=0, class_o=0.
- Hold req_valid_i=1 with class 2 during a 1→4 switch. Without the macro, the request is accepted only in ON(4) and a 2nd sequence ends ON(2). With the macro, it is accepted in SETTLE and ends ON(2) 4 cycles later.
- Drop rst_ni mid-DETACH → all outputs reach reset values without a clock edge. After release, a class 1 request completes normally.
